siso_burst_deser: RTL and testbench

- Downstream consumer of the 2-shift/2-hold serial shift stage.
- Samples the serial bit stream only on cycles where the upstream stage is shifting, and assembles WIDTH-bit words.
- Delivers words through a 2-entry valid/ready output buffer.
- Checks that the upstream shift/hold cadence is honoured and flags overflow and cadence violations as sticky status.

---
 rtl/siso_burst_deser_pkg.sv | 14 +
 rtl/siso_burst_deser_outbuf.sv | 80 ++++++++
 rtl/siso_burst_deser.sv | 137 +++++++++++++
 tb/tb_siso_burst_deser.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_burst_deser_pkg.sv
// Shared definitions for the serial shift stage and its burst deserializer.
// The cadence defaults must match the upstream siso shift stage.
package siso_burst_deser_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    localparam int unsigned SER_SHIFT_CYC = 2;
    localparam int unsigned SER_HOLD_CYC  = 2;

endpackage

// File: rtl/siso_burst_deser_outbuf.sv
// Two-entry output buffer for assembled words.
// Reports when a pushed word has to be dropped because the buffer is full.
module deser_outbuf
    import siso_burst_deser_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] dout,
    output logic             drop,
    output buf_state_e       state
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             pop;

    // Transfer happens on any edge where valid (state != EMPTY) and ready are both high;
    // valid never depends on ready, and the head word is stable while valid & !ready.
    assign pop = (state_q != EMPTY) & pop_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        state_d = ONE;
                    end
                end else if (push) begin
                    drop = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign dout  = head_q;
    assign state = state_q;

endmodule

// File: rtl/siso_burst_deser.sv
// Burst deserializer: samples din only during upstream shift phases, builds WIDTH-bit
// words, buffers them and watches the shift/hold cadence of bit_vld.
module siso_burst_deser
    import siso_burst_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SHIFT_CYC = SER_SHIFT_CYC,
    parameter int unsigned HOLD_CYC  = SER_HOLD_CYC,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             bit_vld,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             ovf,
    output logic             cad_err,
    input  logic             err_clr
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned HI_W  = $clog2(SHIFT_CYC + 2);
    localparam int unsigned LO_W  = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [HI_W-1:0]  HI_REQ   = HI_W'(SHIFT_CYC);
    localparam logic [HI_W-1:0]  HI_MAX   = HI_W'(SHIFT_CYC + 1);
    localparam logic [LO_W-1:0]  LO_REQ   = LO_W'(HOLD_CYC);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [HI_W-1:0]  hi_run_q, hi_run_d;
    logic [LO_W-1:0]  lo_run_q, lo_run_d;
    logic             first_q, first_d;
    logic             ovf_q, ovf_d;
    logic             cad_err_q, cad_err_d;
    logic             push;
    logic             drop;
    logic             cad_set;
    buf_state_e       buf_state;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        if (flush) begin
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else if (bit_vld) begin
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], din} : {din, shreg_q[WIDTH-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                push      = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // first_q exempts the hold check on the first shift run after reset or flush.
    always_comb begin
        hi_run_d = hi_run_q;
        lo_run_d = lo_run_q;
        first_d  = first_q;
        cad_set  = 1'b0;
        if (flush) begin
            hi_run_d = '0;
            lo_run_d = '0;
            first_d  = 1'b1;
        end else if (bit_vld) begin
            lo_run_d = '0;
            if (hi_run_q == '0) begin
                first_d = 1'b0;
                if (!first_q && (lo_run_q < LO_REQ)) begin
                    cad_set = 1'b1;
                end
            end
            if (hi_run_q >= HI_REQ) begin
                cad_set = 1'b1;
            end
            if (hi_run_q != HI_MAX) begin
                hi_run_d = hi_run_q + 1'b1;
            end
        end else begin
            if ((hi_run_q != '0) && (hi_run_q < HI_REQ)) begin
                cad_set = 1'b1;
            end
            hi_run_d = '0;
            if (lo_run_q != LO_REQ) begin
                lo_run_d = lo_run_q + 1'b1;
            end
        end
    end

    assign ovf_d     = drop | (ovf_q & ~err_clr);
    assign cad_err_d = cad_set | (cad_err_q & ~err_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            hi_run_q  <= '0;
            lo_run_q  <= '0;
            first_q   <= 1'b1;
            ovf_q     <= 1'b0;
            cad_err_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            hi_run_q  <= hi_run_d;
            lo_run_q  <= lo_run_d;
            first_q   <= first_d;
            ovf_q     <= ovf_d;
            cad_err_q <= cad_err_d;
        end
    end

    deser_outbuf #(
        .WIDTH(WIDTH)
    ) u_outbuf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(shreg_d),
        .pop_ready(dout_ready),
        .dout     (dout),
        .drop     (drop),
        .state    (buf_state)
    );

    assign dout_valid = (buf_state != EMPTY);
    assign ovf        = ovf_q;
    assign cad_err    = cad_err_q;

endmodule

// File: tb/tb_siso_burst_deser.sv
// Directed and randomized bench for siso_burst_deser with a queue-based reference model.
module tb_siso_burst_deser;

    localparam int W     = 8;
    localparam int SHIFT = 2;
    localparam int HOLD  = 2;
    localparam bit MSB   = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         bit_vld;
    logic         flush;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         ovf;
    logic         cad_err;
    logic         err_clr;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending bits, buffered words, current bit_vld run.
    bit           bits_m[$];
    logic [W-1:0] buf_m[$];
    logic [W-1:0] last_m;
    bit           ovf_m;
    bit           cad_m;
    bit           prev_vld_m;
    bit           first_m;
    int           run_m;

    logic         pre_valid;
    logic         last_valid;
    logic [W-1:0] last_dout;

    always #5 clk = ~clk;

    siso_burst_deser #(
        .WIDTH    (W),
        .SHIFT_CYC(SHIFT),
        .HOLD_CYC (HOLD),
        .MSB_FIRST(MSB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .bit_vld   (bit_vld),
        .flush     (flush),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .ovf       (ovf),
        .cad_err   (cad_err),
        .err_clr   (err_clr)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bits_m.delete();
        buf_m.delete();
        last_m     = '0;
        ovf_m      = 1'b0;
        cad_m      = 1'b0;
        prev_vld_m = 1'b0;
        first_m    = 1'b1;
        run_m      = 0;
    endtask

    task automatic model_edge(input bit d, input bit v, input bit f, input bit r, input bit c);
        bit           pop;
        bit           push;
        bit           cset;
        bit           oset;
        logic [W-1:0] word;
        pop  = (buf_m.size() > 0) && r;
        push = 1'b0;
        cset = 1'b0;
        oset = 1'b0;
        word = '0;
        if (f) begin
            bits_m.delete();
            prev_vld_m = 1'b0;
            run_m      = 0;
            first_m    = 1'b1;
        end else begin
            if (v) begin
                bits_m.push_back(d);
                if (bits_m.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        if (MSB) word[W-1-i] = bits_m[i];
                        else     word[i]     = bits_m[i];
                    end
                    push = 1'b1;
                    bits_m.delete();
                end
            end
            if (v != prev_vld_m) begin
                if (prev_vld_m && run_m < SHIFT) cset = 1'b1;
                if (!prev_vld_m && run_m < HOLD && !first_m) cset = 1'b1;
                if (v) first_m = 1'b0;
                prev_vld_m = v;
                run_m      = 1;
            end else begin
                run_m++;
            end
            if (v && run_m > SHIFT) cset = 1'b1;
        end
        if (pop) void'(buf_m.pop_front());
        if (push) begin
            if (buf_m.size() < 2) buf_m.push_back(word);
            else oset = 1'b1;
        end
        ovf_m = oset ? 1'b1 : (c ? 1'b0 : ovf_m);
        cad_m = cset ? 1'b1 : (c ? 1'b0 : cad_m);
        if (buf_m.size() > 0) last_m = buf_m[0];
    endtask

    task automatic cycle(input bit d, input bit v, input bit f, input bit r, input bit c);
        din        = d;
        bit_vld    = v;
        flush      = f;
        dout_ready = r;
        err_clr    = c;
        @(posedge clk);
        model_edge(d, v, f, r, c);
        #1;
        check("dout_valid", W'(dout_valid), W'(buf_m.size() > 0));
        check("dout", dout, last_m);
        check("ovf", W'(ovf), W'(ovf_m));
        check("cad_err", W'(cad_err), W'(cad_m));
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, r, 1'b0);
    endtask

    // Two bits per shift run, then two hold cycles; ready can differ on the last bit.
    task automatic send_word(input logic [W-1:0] word, input bit r, input bit r_last);
        for (int i = 0; i < W; i++) begin
            cycle(word[W-1-i], 1'b1, 1'b0, (i == W - 1) ? r_last : r, 1'b0);
            if (i == W - 2) pre_valid = dout_valid;
            if (i == W - 1) begin
                last_valid = dout_valid;
                last_dout  = dout;
            end
            if (i % 2 == 1) idle(2, r);
        end
    endtask

    task automatic rcycle(input bit v);
        cycle(1'($urandom_range(0, 1)), v, $urandom_range(0, 59) == 0,
              $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    endtask

    initial begin
        rst        = 1'b1;
        din        = 1'b0;
        bit_vld    = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b0;
        err_clr    = 1'b0;
        model_reset();
        #2;
        check("reset_dout", dout, '0);
        check("reset_valid", W'(dout_valid), '0);
        check("reset_ovf", W'(ovf), '0);
        check("reset_cad", W'(cad_err), '0);
        @(negedge clk);
        rst = 1'b0;

        // Nominal word, ready held high.
        idle(2, 1'b1);
        send_word(8'hB2, 1'b1, 1'b1);
        check("nominal_pre_valid", W'(pre_valid), '0);
        check("nominal_valid", W'(last_valid), 8'd1);
        check("nominal_dout", last_dout, 8'hB2);
        check("nominal_cad", W'(cad_err), '0);

        // Backpressure: third word dropped.
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b0);
        check("bp_head", dout, 8'h11);
        check("bp_ovf", W'(ovf), 8'd1);
        idle(1, 1'b1);
        check("bp_pop1", dout, 8'h22);
        idle(1, 1'b1);
        check("bp_empty", W'(dout_valid), '0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("bp_ovf_clr", W'(ovf), '0);

        // Push and pop on the same edge while full.
        send_word(8'hA1, 1'b0, 1'b0);
        send_word(8'hA2, 1'b0, 1'b0);
        send_word(8'hA3, 1'b0, 1'b1);
        check("pp_head", last_dout, 8'hA2);
        check("pp_ovf", W'(ovf), '0);
        idle(1, 1'b1);
        check("pp_second", dout, 8'hA3);
        idle(1, 1'b1);
        check("pp_empty", W'(dout_valid), '0);

        // Over-long shift run, then clear, then short hold run.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("cad_before", W'(cad_err), '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("cad_long_run", W'(cad_err), 8'd1);
        idle(2, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("cad_clr", W'(cad_err), '0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("cad_short_hold", W'(cad_err), 8'd1);
        idle(1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("cad_clr2", W'(cad_err), '0);

        // Flush mid-word, then a fresh word starting right away.
        idle(2, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_word(8'h5A, 1'b1, 1'b1);
        check("flush_dout", last_dout, 8'h5A);
        check("flush_valid", W'(last_valid), 8'd1);
        check("flush_cad", W'(cad_err), '0);

        // Randomized cadence, data, backpressure, flushes and clears.
        for (int r = 0; r < 60; r++) begin
            int hl;
            int ll;
            hl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : SHIFT;
            ll = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(HOLD, HOLD + 3));
            for (int k = 0; k < hl; k++) rcycle(1'b1);
            for (int k = 0; k < ll; k++) rcycle(1'b0);
        end

        // Asynchronous reset with a full buffer, ovf set and a partial word.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);
        send_word(8'h0F, 1'b0, 1'b0);
        send_word(8'hF0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0);
        check("pre_rst_ovf", W'(ovf), 8'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i % 2 == 1) idle(2, 1'b0);
        end
        #2;
        rst     = 1'b1;
        bit_vld = 1'b0;
        #1;
        model_reset();
        check("arst_valid", W'(dout_valid), '0);
        check("arst_ovf", W'(ovf), '0);
        check("arst_dout", dout, '0);
        @(negedge clk);
        rst = 1'b0;
        send_word(8'hC3, 1'b1, 1'b1);
        check("arst_word", last_dout, 8'hC3);
        check("arst_word_valid", W'(last_valid), 8'd1);
        check("arst_cad", W'(cad_err), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
